read_frame_func: RTL and testbench
==================================

Name: read_frame_func

Overview:
- Receive-side counterpart of the HLS byte-writer that drives eth_axis_tx.
- Consumes one Ethernet frame from an eth_axis_rx-style master interface (arg_2): header handshake, then payload stream.
- Stores payload bytes into an external byte memory (arg_0).
- Exposes captured header fields, frame length and error flags, then asserts valid.
- Same HLS-function shape as the rest of the codebase: single-shot after reset, terminal state holds valid.

Parameters:
- DEPTH, 256, payload buffer capacity in bytes (power of two).
- ADDR_W, 8, log2(DEPTH); width of arg_0 addresses.
- LEN_W, 9, ADDR_W+1; width of rx_len (must represent DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (0 = reset).
- arg_0_raddr  out  ADDR_W  unused; tied 0.
- arg_0_waddr  out  ADDR_W  payload buffer write address.
- arg_0_wdata  out  8  payload byte.
- arg_0_wen  out  1  write enable, combinational.
- arg_0_rdata  in  8  unused.
- arg_2_m_eth_hdr_valid  in  1  header valid.
- arg_2_m_eth_hdr_ready  out  1  header ready.
- arg_2_m_eth_dest_mac  in  48  header field.
- arg_2_m_eth_src_mac  in  48  header field.
- arg_2_m_eth_type  in  16  header field.
- arg_2_m_eth_payload_axis_tdata  in  8  payload byte.
- arg_2_m_eth_payload_axis_tvalid  in  1  payload valid.
- arg_2_m_eth_payload_axis_tlast  in  1  last payload byte.
- arg_2_m_eth_payload_axis_tuser  in  1  frame error marker (sampled on tlast beat).
- arg_2_m_eth_payload_axis_tready  out  1  payload ready.
- rx_dest_mac  out  48  latched dest MAC.
- rx_src_mac  out  48  latched source MAC.
- rx_type  out  16  latched ethertype.
- rx_len  out  LEN_W  bytes stored in arg_0.
- rx_overflow  out  1  frame exceeded DEPTH bytes.
- rx_err  out  1  tuser was set on the tlast beat.
- valid  out  1  frame complete; results stable.

Behaviour:
- Reset: when rst==0 at a clk edge:
  - state<=WAIT_HDR; count, rx_len, rx_overflow, rx_err, header regs <= 0.
  - While rst==0, hdr_ready, tready, wen and valid are forced to 0.
  - arg_0 contents are not cleared.
- States: WAIT_HDR=0, PAYLOAD=1, DRAIN=2, DONE=3.
- WAIT_HDR:
  - hdr_ready=1, tready=0.
  - On hdr_valid: latch dest/src/type, count<=0, go PAYLOAD.
  - Payload beats arriving early are stalled, never written.
- PAYLOAD:
  - tready=1.
  - On tvalid, same cycle: wen=1, waddr=count[ADDR_W-1:0], wdata=tdata; count<=count+1; rx_len<=count+1.
  - tvalid low: wen=0, nothing changes; a bubble does not advance the address.
  - Beat with tlast: rx_err<=tuser; go DONE.
  - Beat without tlast with count==DEPTH-1: rx_overflow<=1; go DRAIN. That beat is still written (address DEPTH-1, rx_len=DEPTH).
  - tlast at count==DEPTH-1 is a normal completion, not an overflow.
- DRAIN:
  - tready=1, wen=0; beats are discarded.
  - On tvalid&tlast: rx_err<=tuser; go DONE.
- DONE:
  - valid=1, hdr_ready=0, tready=0.
  - Held until reset.
  - rx_* outputs stable from the first DONE cycle.
- Latency:
  - Write is zero-cycle: combinational from the accepted beat.
  - valid rises on the first clk edge after the tlast beat is accepted.
- Minimum frame: 1 byte; a frame whose first beat carries tlast gives rx_len=1.
- count is LEN_W wide and never wraps: overflow stops writing before the address could wrap.
- Reset mid-frame:
  - Abandons the frame; returns to WAIT_HDR.
  - The upstream remainder of the frame is stalled (tready=0) until the next header is accepted.
- hdr_valid and payload tvalid in the same WAIT_HDR cycle: only the header is accepted; the payload is taken from the next cycle.

Decomposition:
- Shared package read_frame_pkg:
  - state enum (WAIT_HDR, PAYLOAD, DRAIN, DONE).
  - DEPTH, ADDR_W, LEN_W defaults.
  - ETH_MAC_W=48, ETH_TYPE_W=16.
- Sub-modules:
  - read_frame_func_inner holds the FSM, counter and registers.
  - read_frame_func is a thin wrapper instantiating it by name-matched ports, consistent with other generated functions.
  - No further sub-modules.

Test Plan:
- Basic frame:
  - Stimulus: release reset; header dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800; 4 beats 0xAA,0xBB,0xCC,0xDD, tlast on 4th.
  - Response: wen at waddr 0..3 with those bytes; valid=1 the next cycle; rx_len=4; rx_type=0x0800; rx_err=0; rx_overflow=0.
- Bubbles:
  - Stimulus: 3-byte frame with tvalid low for 2 cycles between each beat.
  - Response: exactly 3 wen pulses at waddr 0,1,2; rx_len=3.
- Overflow:
  - Stimulus: DEPTH=256; 300-byte frame.
  - Response: 256 writes (addr 0..255); rx_overflow=1; remaining 44 beats accepted with tready=1 and wen=0; valid after tlast; rx_len=256.
- Exact fit:
  - Stimulus: 256-byte frame, tlast on beat 256.
  - Response: rx_overflow=0, rx_len=256.
- Error:
  - Stimulus: 2-byte frame with tuser=1 on the tlast beat.
  - Response: rx_err=1, valid=1.
- Early payload, then reset mid-frame:
  - Stimulus: tvalid asserted before the header.
  - Response: tready=0, no wen.
  - Stimulus: after 2 stored bytes, drive rst=0 for 1 cycle, then send a new 1-byte frame 0x5A.
  - Response: write at waddr 0, rx_len=1, valid=1.

Source files
------------

// File: rtl/read_frame_pkg.sv
// Shared types and constants for the Ethernet frame reader.
package read_frame_pkg;

  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_LEN_W  = 9;
  localparam int unsigned ETH_MAC_W  = 48;
  localparam int unsigned ETH_TYPE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_HDR = 2'd0;
  localparam state_t PAYLOAD  = 2'd1;
  localparam state_t DRAIN    = 2'd2;
  localparam state_t DONE     = 2'd3;

  typedef struct packed {
    logic [ETH_MAC_W-1:0]  dest_mac;
    logic [ETH_MAC_W-1:0]  src_mac;
    logic [ETH_TYPE_W-1:0] eth_type;
  } eth_hdr_t;

endpackage

// File: rtl/read_frame_func_if.sv
// eth_axis_rx-style header + payload stream; the frame source is the master.
interface read_frame_func_if;

  logic                                  m_eth_hdr_valid;
  logic                                  m_eth_hdr_ready;
  logic [read_frame_pkg::ETH_MAC_W-1:0]  m_eth_dest_mac;
  logic [read_frame_pkg::ETH_MAC_W-1:0]  m_eth_src_mac;
  logic [read_frame_pkg::ETH_TYPE_W-1:0] m_eth_type;
  logic [7:0]                            m_eth_payload_axis_tdata;
  logic                                  m_eth_payload_axis_tvalid;
  logic                                  m_eth_payload_axis_tlast;
  logic                                  m_eth_payload_axis_tuser;
  logic                                  m_eth_payload_axis_tready;

  modport master (
    output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    input  m_eth_hdr_ready, m_eth_payload_axis_tready
  );

  modport slave (
    input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    output m_eth_hdr_ready, m_eth_payload_axis_tready
  );

endinterface

// File: rtl/read_frame_func_inner.sv
// Frame capture FSM: latches the header, writes payload bytes to the buffer,
// drains oversize frames and holds the results once the frame is complete.
module read_frame_func_inner
  import read_frame_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_W-1:0]     arg_0_raddr,
  output logic [ADDR_W-1:0]     arg_0_waddr,
  output logic [7:0]            arg_0_wdata,
  output logic                  arg_0_wen,
  input  logic [7:0]            arg_0_rdata,
  read_frame_func_if.slave      arg_2,
  output logic [ETH_MAC_W-1:0]  rx_dest_mac,
  output logic [ETH_MAC_W-1:0]  rx_src_mac,
  output logic [ETH_TYPE_W-1:0] rx_type,
  output logic [LEN_W-1:0]      rx_len,
  output logic                  rx_overflow,
  output logic                  rx_err,
  output logic                  valid
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] count, count_nx;
  logic [LEN_W-1:0] len_nx;
  logic             ovf_nx, err_nx;
  eth_hdr_t         hdr_q, hdr_nx;
  logic             hdr_ready, tready, wen, done;

  logic unused_rdata;
  assign unused_rdata = ^arg_0_rdata;

  // Next-state and handshake decode; reset forces every strobe low.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    len_nx    = rx_len;
    ovf_nx    = rx_overflow;
    err_nx    = rx_err;
    hdr_nx    = hdr_q;
    hdr_ready = 1'b0;
    tready    = 1'b0;
    wen       = 1'b0;
    done      = 1'b0;
    case (state)
      WAIT_HDR: begin
        hdr_ready = 1'b1;
        if (arg_2.m_eth_hdr_valid) begin
          hdr_nx   = '{dest_mac: arg_2.m_eth_dest_mac,
                       src_mac:  arg_2.m_eth_src_mac,
                       eth_type: arg_2.m_eth_type};
          count_nx = '0;
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        tready = 1'b1;
        if (arg_2.m_eth_payload_axis_tvalid) begin
          wen      = 1'b1;
          count_nx = count + LEN_W'(1);
          len_nx   = count + LEN_W'(1);
          if (arg_2.m_eth_payload_axis_tlast) begin
            err_nx   = arg_2.m_eth_payload_axis_tuser;
            state_nx = DONE;
          end else if (count == LEN_W'(DEPTH - 1)) begin
            // Buffer full before tlast: stop writing before the address wraps.
            ovf_nx   = 1'b1;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        tready = 1'b1;
        if (arg_2.m_eth_payload_axis_tvalid && arg_2.m_eth_payload_axis_tlast) begin
          err_nx   = arg_2.m_eth_payload_axis_tuser;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nx = WAIT_HDR;
      end
    endcase
    if (!rst) begin
      hdr_ready = 1'b0;
      tready    = 1'b0;
      wen       = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT_HDR;
      count       <= '0;
      rx_len      <= '0;
      rx_overflow <= 1'b0;
      rx_err      <= 1'b0;
      hdr_q       <= '0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      rx_len      <= len_nx;
      rx_overflow <= ovf_nx;
      rx_err      <= err_nx;
      hdr_q       <= hdr_nx;
    end
  end

  assign arg_2.m_eth_hdr_ready           = hdr_ready;
  assign arg_2.m_eth_payload_axis_tready = tready;
  assign arg_0_raddr = '0;
  assign arg_0_waddr = count[ADDR_W-1:0];
  assign arg_0_wdata = arg_2.m_eth_payload_axis_tdata;
  assign arg_0_wen   = wen;
  assign valid       = done;
  assign rx_dest_mac = hdr_q.dest_mac;
  assign rx_src_mac  = hdr_q.src_mac;
  assign rx_type     = hdr_q.eth_type;

endmodule

// File: rtl/read_frame_func.sv
// Top-level wrapper for the frame reader function.
module read_frame_func
  import read_frame_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_W-1:0]     arg_0_raddr,
  output logic [ADDR_W-1:0]     arg_0_waddr,
  output logic [7:0]            arg_0_wdata,
  output logic                  arg_0_wen,
  input  logic [7:0]            arg_0_rdata,
  read_frame_func_if.slave      arg_2,
  output logic [ETH_MAC_W-1:0]  rx_dest_mac,
  output logic [ETH_MAC_W-1:0]  rx_src_mac,
  output logic [ETH_TYPE_W-1:0] rx_type,
  output logic [LEN_W-1:0]      rx_len,
  output logic                  rx_overflow,
  output logic                  rx_err,
  output logic                  valid
);

  read_frame_func_inner #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) read_frame_func_inner (
    .clk         (clk),
    .rst         (rst),
    .arg_0_raddr (arg_0_raddr),
    .arg_0_waddr (arg_0_waddr),
    .arg_0_wdata (arg_0_wdata),
    .arg_0_wen   (arg_0_wen),
    .arg_0_rdata (arg_0_rdata),
    .arg_2       (arg_2),
    .rx_dest_mac (rx_dest_mac),
    .rx_src_mac  (rx_src_mac),
    .rx_type     (rx_type),
    .rx_len      (rx_len),
    .rx_overflow (rx_overflow),
    .rx_err      (rx_err),
    .valid       (valid)
  );

endmodule

// File: tb/tb_read_frame_func.sv
// Bench for read_frame_func: table of directed frames, a mid-frame reset
// sequence and random frames checked against a min(len, DEPTH) buffer model.
module tb_read_frame_func;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  read_frame_func_if bus();

  logic [ADDR_W-1:0] raddr, waddr;
  logic [7:0]        wdata;
  logic [7:0]        rdata = 8'h00;
  logic              wen;
  logic [47:0]       rx_dest, rx_src;
  logic [15:0]       rx_type;
  logic [LEN_W-1:0]  rx_len;
  logic              rx_ovf, rx_err, valid;

  read_frame_func #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .arg_0_raddr (raddr),
    .arg_0_waddr (waddr),
    .arg_0_wdata (wdata),
    .arg_0_wen   (wen),
    .arg_0_rdata (rdata),
    .arg_2       (bus),
    .rx_dest_mac (rx_dest),
    .rx_src_mac  (rx_src),
    .rx_type     (rx_type),
    .rx_len      (rx_len),
    .rx_overflow (rx_ovf),
    .rx_err      (rx_err),
    .valid       (valid)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] wlog[$];
  bit seen_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs are driven on the falling edge; outputs are sampled 1ns later.
  task automatic cycle(output logic hr, output logic tr);
    #1;
    hr = bus.m_eth_hdr_ready;
    tr = bus.m_eth_payload_axis_tready;
    if (wen === 1'b1) wlog.push_back({waddr, wdata});
    if (valid === 1'b1) seen_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_strobes", {bus.m_eth_hdr_ready, bus.m_eth_payload_axis_tready, wen, valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_len", rx_len, 0);
    chk("reset_flags", {rx_ovf, rx_err, valid}, 3'b000);
    chk("reset_ready", {bus.m_eth_hdr_ready, bus.m_eth_payload_axis_tready}, 2'b10);
    chk("reset_raddr", raddr, 0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pl[$], input int gap,
                           input logic tuser, input logic [47:0] dest, input logic [47:0] src,
                           input logic [15:0] etype, input int exp_len, input logic exp_ovf,
                           input logic exp_err);
    logic hr, tr, ok, any_rdy;
    logic [15:0] exp_w[$];
    int nbad;
    int n_stored;
    wlog.delete();
    seen_valid = 1'b0;
    bus.m_eth_payload_axis_tvalid = 1'b0;
    bus.m_eth_hdr_valid = 1'b1;
    bus.m_eth_dest_mac  = dest;
    bus.m_eth_src_mac   = src;
    bus.m_eth_type      = etype;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin cycle(hr, tr); ok = hr; end
    bus.m_eth_hdr_valid = 1'b0;
    bus.m_eth_dest_mac  = 48'($urandom);
    if (!ok) begin chk({tag, "_hdr_timeout"}, 0, 1); return; end
    for (int i = 0; i < pl.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.m_eth_payload_axis_tvalid = 1'b0;
          bus.m_eth_payload_axis_tdata  = 8'($urandom);
          cycle(hr, tr);
        end
      end
      bus.m_eth_payload_axis_tvalid = 1'b1;
      bus.m_eth_payload_axis_tdata  = pl[i];
      bus.m_eth_payload_axis_tlast  = (i == pl.size() - 1);
      bus.m_eth_payload_axis_tuser  = (i == pl.size() - 1) ? tuser : 1'($urandom_range(0, 1));
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin cycle(hr, tr); ok = tr; end
      if (!ok) begin
        bus.m_eth_payload_axis_tvalid = 1'b0;
        chk({tag, "_beat_timeout"}, i, -1);
        return;
      end
    end
    bus.m_eth_payload_axis_tvalid = 1'b0;
    bus.m_eth_payload_axis_tlast  = 1'b0;
    bus.m_eth_payload_axis_tuser  = 1'b0;
    // Reference: the first min(len, DEPTH) bytes land at consecutive addresses.
    n_stored = (pl.size() > DEPTH) ? DEPTH : pl.size();
    for (int i = 0; i < n_stored; i++) exp_w.push_back({8'(i), pl[i]});
    chk({tag, "_early_valid"}, seen_valid, 0);
    #1;
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_len"}, rx_len, exp_len);
    chk({tag, "_model_len"}, rx_len, n_stored);
    chk({tag, "_ovf"}, rx_ovf, exp_ovf);
    chk({tag, "_err"}, rx_err, exp_err);
    chk({tag, "_hdr"}, {rx_type, rx_dest ^ rx_src}, {etype, dest ^ src});
    chk({tag, "_dest"}, rx_dest, dest);
    chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
    nbad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (i >= wlog.size() || wlog[i] !== exp_w[i]) nbad++;
    chk({tag, "_wbytes_bad"}, nbad, 0);
    @(negedge clk);
    bus.m_eth_hdr_valid = 1'b1;
    bus.m_eth_payload_axis_tvalid = 1'b1;
    bus.m_eth_payload_axis_tlast  = 1'b1;
    bus.m_eth_payload_axis_tuser  = ~exp_err;
    any_rdy = 1'b0;
    repeat (3) begin cycle(hr, tr); any_rdy = any_rdy | hr | tr; end
    bus.m_eth_hdr_valid = 1'b0;
    bus.m_eth_payload_axis_tvalid = 1'b0;
    bus.m_eth_payload_axis_tlast  = 1'b0;
    bus.m_eth_payload_axis_tuser  = 1'b0;
    #1;
    chk({tag, "_hold"}, {any_rdy, valid, rx_err, rx_len}, {1'b0, 1'b1, exp_err, LEN_W'(exp_len)});
    chk({tag, "_hold_nwrites"}, wlog.size(), exp_w.size());
    @(negedge clk);
  endtask

  typedef struct {
    string       tag;
    int          n;
    int          gap;
    logic [7:0]  base;
    logic        tuser;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          exp_len;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic hr, tr, any_tr;
    logic [7:0] pl[$];
    bus.m_eth_hdr_valid = 1'b0;
    bus.m_eth_dest_mac  = '0;
    bus.m_eth_src_mac   = '0;
    bus.m_eth_type      = '0;
    bus.m_eth_payload_axis_tdata  = '0;
    bus.m_eth_payload_axis_tvalid = 1'b0;
    bus.m_eth_payload_axis_tlast  = 1'b0;
    bus.m_eth_payload_axis_tuser  = 1'b0;

    vecs.push_back('{"basic",    4,   0, 8'hAA, 1'b0, 48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 4,   1'b0, 1'b0});
    vecs.push_back('{"bubbles",  3,   2, 8'h10, 1'b0, 48'h010203040506, 48'hA1A2A3A4A5A6, 16'h86DD, 3,   1'b0, 1'b0});
    vecs.push_back('{"overflow", 300, 0, 8'h01, 1'b0, 48'hFFFFFFFFFFFF, 48'h000000000001, 16'h0806, 256, 1'b1, 1'b0});
    vecs.push_back('{"exact",    256, 0, 8'h37, 1'b0, 48'h123456789ABC, 48'hCBA987654321, 16'h8100, 256, 1'b0, 1'b0});
    vecs.push_back('{"error",    2,   1, 8'h55, 1'b1, 48'hDEADBEEF0001, 48'hDEADBEEF0002, 16'h0800, 2,   1'b0, 1'b1});
    vecs.push_back('{"min1",     1,   0, 8'hC3, 1'b0, 48'h0000000000AA, 48'h0000000000BB, 16'h0001, 1,   1'b0, 1'b0});
    vecs.push_back('{"ovf_err",  258, 1, 8'h80, 1'b1, 48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'hFFFF, 256, 1'b1, 1'b1});

    @(negedge clk);
    foreach (vecs[v]) begin
      do_reset();
      pl.delete();
      for (int i = 0; i < vecs[v].n; i++) pl.push_back(8'(vecs[v].base + 8'(i) * 8'h11));
      run_frame(vecs[v].tag, pl, vecs[v].gap, vecs[v].tuser, vecs[v].dest, vecs[v].src,
                vecs[v].etype, vecs[v].exp_len, vecs[v].exp_ovf, vecs[v].exp_err);
    end

    // Early payload, header alongside a beat, then reset mid-frame.
    do_reset();
    wlog.delete();
    bus.m_eth_payload_axis_tvalid = 1'b1;
    bus.m_eth_payload_axis_tdata  = 8'h77;
    any_tr = 1'b0;
    repeat (3) begin cycle(hr, tr); any_tr = any_tr | tr; end
    chk("early_tready", any_tr, 0);
    chk("early_wen", wlog.size(), 0);
    bus.m_eth_hdr_valid = 1'b1;
    bus.m_eth_type      = 16'h0800;
    cycle(hr, tr);
    bus.m_eth_hdr_valid = 1'b0;
    chk("same_cycle_hdr_taken", hr, 1);
    chk("same_cycle_no_wen", wlog.size(), 0);
    cycle(hr, tr);
    bus.m_eth_payload_axis_tdata = 8'h78;
    cycle(hr, tr);
    chk("midframe_nwrites", wlog.size(), 2);
    chk("midframe_w0", wlog.size() > 0 ? wlog[0] : 16'hXXXX, {8'd0, 8'h77});
    chk("midframe_w1", wlog.size() > 1 ? wlog[1] : 16'hXXXX, {8'd1, 8'h78});
    bus.m_eth_payload_axis_tdata = 8'h79;
    do_reset();
    any_tr = 1'b0;
    repeat (2) begin cycle(hr, tr); any_tr = any_tr | tr; end
    chk("post_reset_stall", any_tr, 0);
    chk("post_reset_no_wen", wlog.size(), 2);
    pl.delete();
    pl.push_back(8'h5A);
    run_frame("reset_recover", pl, 0, 1'b0, 48'h0102030405AA, 48'h0102030405BB, 16'h88CC,
              1, 1'b0, 1'b0);

    // Random frames; expectations follow from length/DEPTH arithmetic alone.
    for (int r = 0; r < 12; r++) begin
      int n;
      logic tu;
      case (r % 4)
        0: n = $urandom_range(1, 40);
        1: n = 255 + $urandom_range(0, 2);
        default: n = $urandom_range(1, 300);
      endcase
      tu = 1'($urandom_range(0, 1));
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      do_reset();
      run_frame($sformatf("rand%0d", r), pl, $urandom_range(0, 2), tu,
                48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom),
                (n > DEPTH) ? DEPTH : n, n > DEPTH, tu);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
